wb_retire_queue: RTL and testbench

Parametrised LoongArch writeback/retire stage; successor to the single-entry WB register.
- Buffers up to DEPTH completed MEM-stage instructions in order and retires at most one per cycle.
- Supports a retire stall from trace/CSR back-pressure.
- Resolves prioritised exceptions, including ADEM and a bad-vaddr output.
- Exports a pending-write scoreboard mask to ID.

---
 rtl/wb_pkg.sv | 78 +++++++
 rtl/wb_retire_queue_if.sv | 12 +
 rtl/wb_exc_encode.sv | 36 +++
 rtl/wb_retire_queue.sv | 157 +++++++++++++++
 tb/tb_wb_retire_queue.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/retire stage: MEM->WB bus layout,
// exception bit positions and LoongArch exception codes.
package wb_pkg;

    localparam int BUS_W = 190;

    // Bus field LSB positions, MSB-first: pc, exc7, ertn, vaddr, rf_we, rf_waddr,
    // rf_wdata, csr_re, csr_we, csr_num, csr_wmask, csr_wvalue
    localparam int PC_LSB         = 158;
    localparam int EXC_LSB        = 151;
    localparam int ERTN_BIT       = 150;
    localparam int VADDR_LSB      = 118;
    localparam int RF_WE_BIT      = 117;
    localparam int RF_WADDR_LSB   = 112;
    localparam int RF_WDATA_LSB   = 80;
    localparam int CSR_RE_BIT     = 79;
    localparam int CSR_WE_BIT     = 78;
    localparam int CSR_NUM_LSB    = 64;
    localparam int CSR_WMASK_LSB  = 32;
    localparam int CSR_WVALUE_LSB = 0;

    localparam int EXC_INT  = 6;
    localparam int EXC_ADEF = 5;
    localparam int EXC_ADEM = 4;
    localparam int EXC_ALE  = 3;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 1;
    localparam int EXC_INE  = 0;

    localparam logic [5:0] ECODE_INT = 6'h0;
    localparam logic [5:0] ECODE_ADE = 6'h8;
    localparam logic [5:0] ECODE_ALE = 6'h9;
    localparam logic [5:0] ECODE_SYS = 6'hB;
    localparam logic [5:0] ECODE_BRK = 6'hC;
    localparam logic [5:0] ECODE_INE = 6'hD;

    localparam logic [8:0] ESUB_NONE = 9'd0;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    typedef enum logic [1:0] {
        VSEL_NONE  = 2'd0,
        VSEL_PC    = 2'd1,
        VSEL_VADDR = 2'd2
    } vaddr_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  exc;
        logic        ertn;
        logic [31:0] vaddr;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } wb_entry_t;

    function automatic wb_entry_t unpack_bus(input logic [BUS_W-1:0] bus);
        wb_entry_t e;
        e.pc         = bus[PC_LSB +: 32];
        e.exc        = bus[EXC_LSB +: 7];
        e.ertn       = bus[ERTN_BIT];
        e.vaddr      = bus[VADDR_LSB +: 32];
        e.rf_we      = bus[RF_WE_BIT];
        e.rf_waddr   = bus[RF_WADDR_LSB +: 5];
        e.rf_wdata   = bus[RF_WDATA_LSB +: 32];
        e.csr_re     = bus[CSR_RE_BIT];
        e.csr_we     = bus[CSR_WE_BIT];
        e.csr_num    = bus[CSR_NUM_LSB +: 14];
        e.csr_wmask  = bus[CSR_WMASK_LSB +: 32];
        e.csr_wvalue = bus[CSR_WVALUE_LSB +: 32];
        return e;
    endfunction

endpackage

// File: rtl/wb_retire_queue_if.sv
// MEM->WB handshake: MEM drives valid and the instruction bus, WB answers allowin.
interface wb_retire_queue_if;
    import wb_pkg::*;

    logic             ms2ws_valid;
    logic             ws_allowin;
    logic [BUS_W-1:0] ms2ws_bus;

    modport master (output ms2ws_valid, output ms2ws_bus, input ws_allowin);
    modport slave  (input ms2ws_valid, input ms2ws_bus, output ws_allowin);

endinterface

// File: rtl/wb_exc_encode.sv
// Prioritised exception encoder: exc7 -> ecode/esubcode and bad-vaddr source.
module wb_exc_encode
    import wb_pkg::*;
(
    input  logic [6:0] exc,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output vaddr_sel_e vaddr_sel
);

    always_comb begin
        ecode     = ECODE_INT;
        esubcode  = ESUB_NONE;
        vaddr_sel = VSEL_NONE;
        if (exc[EXC_INT]) begin
            ecode = ECODE_INT;
        end else if (exc[EXC_ADEF]) begin
            ecode     = ECODE_ADE;
            vaddr_sel = VSEL_PC;
        end else if (exc[EXC_ADEM]) begin
            ecode     = ECODE_ADE;
            esubcode  = ESUB_ADEM;
            vaddr_sel = VSEL_VADDR;
        end else if (exc[EXC_ALE]) begin
            ecode     = ECODE_ALE;
            vaddr_sel = VSEL_VADDR;
        end else if (exc[EXC_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc[EXC_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc[EXC_INE]) begin
            ecode = ECODE_INE;
        end
    end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback/retire queue: buffers up to DEPTH MEM results, retires one
// per cycle, resolves exceptions/ertn into a full flush, and exports pending writes.
module wb_retire_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    wb_retire_queue_if.slave    ms2ws,
    input  logic                wb_stall,
    output logic                csr_re,
    output logic [13:0]         csr_num,
    input  logic [31:0]         csr_rvalue,
    output logic                csr_we,
    output logic [31:0]         csr_wmask,
    output logic [31:0]         csr_wvalue,
    output logic                ertn_flush,
    output logic                wb_ex,
    output logic [31:0]         wb_pc,
    output logic [5:0]          wb_ecode,
    output logic [8:0]          wb_esubcode,
    output logic [31:0]         wb_vaddr,
    output logic [37:0]         ws_rf_zip,
    output logic [31:0]         ws_pend_mask,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [BUS_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;

    wb_entry_t  head;
    logic       head_valid;
    logic       has_exc;
    logic       retire;
    logic       allowin;
    logic       enq;
    logic       flush;
    logic       rf_we_eff;
    logic [4:0] head_waddr;
    logic [31:0] head_wdata;
    logic [31:0] pend;
    logic [5:0] enc_ecode;
    logic [8:0] enc_esub;
    vaddr_sel_e enc_vsel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // allowin looks only at registered occupancy, so a full queue stays closed
    // even in a cycle where the head retires.
    assign allowin          = reset || (count < FULL_CNT);
    assign ms2ws.ws_allowin = allowin;
    assign enq              = ms2ws.ms2ws_valid && allowin && !reset;

    assign head       = unpack_bus(mem[head_ptr]);
    assign head_valid = (count != '0) && !reset;
    assign has_exc    = head_valid && (head.exc != 7'd0);
    assign retire     = head_valid && !wb_stall;

    assign wb_ex      = retire && has_exc;
    assign ertn_flush = retire && head.ertn && !has_exc;
    assign flush      = wb_ex || ertn_flush;
    assign rf_we_eff  = retire && head.rf_we && !has_exc;

    assign csr_re     = head_valid && head.csr_re;
    assign csr_num    = head_valid ? head.csr_num : 14'd0;
    assign csr_we     = retire && head.csr_we && !has_exc;
    assign csr_wmask  = head_valid ? head.csr_wmask : 32'd0;
    assign csr_wvalue = head_valid ? head.csr_wvalue : 32'd0;
    assign wb_pc      = head_valid ? head.pc : 32'd0;

    wb_exc_encode u_exc_encode (
        .exc       (head.exc),
        .ecode     (enc_ecode),
        .esubcode  (enc_esub),
        .vaddr_sel (enc_vsel)
    );

    assign wb_ecode    = wb_ex ? enc_ecode : 6'd0;
    assign wb_esubcode = wb_ex ? enc_esub : 9'd0;

    always_comb begin
        wb_vaddr = 32'd0;
        if (wb_ex) begin
            case (enc_vsel)
                VSEL_PC:    wb_vaddr = head.pc;
                VSEL_VADDR: wb_vaddr = head.vaddr;
                default:    wb_vaddr = 32'd0;
            endcase
        end
    end

    // CSR reads return data combinationally in the retire cycle.
    assign head_waddr = head_valid ? head.rf_waddr : 5'd0;
    assign head_wdata = !head_valid ? 32'd0 : (head.csr_re ? csr_rvalue : head.rf_wdata);
    assign ws_rf_zip  = {rf_we_eff, head_waddr, head_wdata};

    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{ws_rf_zip[37]}};
    assign debug_wb_rf_wnum  = head_waddr;
    assign debug_wb_rf_wdata = ws_rf_zip[31:0];

    always_comb begin
        pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && mem[i][RF_WE_BIT] && (mem[i][RF_WADDR_LSB +: 5] != 5'd0)) begin
                pend[mem[i][RF_WADDR_LSB +: 5]] = 1'b1;
            end
        end
    end

    assign ws_pend_mask = reset ? 32'd0 : pend;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail_ptr] <= ms2ws.ms2ws_bus;
        end
    end

    // Flush drops everything, including an instruction arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            vld      <= '0;
        end else begin
            if (enq) begin
                vld[tail_ptr] <= 1'b1;
                tail_ptr      <= ptr_inc(tail_ptr);
            end
            if (retire) begin
                vld[head_ptr] <= 1'b0;
                head_ptr      <= ptr_inc(head_ptr);
            end
            if (enq && !retire) begin
                count <= count + 1'b1;
            end else if (retire && !enq) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue with a queue-based reference of accepted entries.
module tb_wb_retire_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        wb_stall;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn_flush;
    logic        wb_ex;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic [37:0] ws_rf_zip;
    logic [31:0] ws_pend_mask;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_retire_queue_if bus_if ();

    wb_retire_queue #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms2ws             (bus_if),
        .wb_stall          (wb_stall),
        .csr_re            (csr_re),
        .csr_num           (csr_num),
        .csr_rvalue        (csr_rvalue),
        .csr_we            (csr_we),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .ertn_flush        (ertn_flush),
        .wb_ex             (wb_ex),
        .wb_pc             (wb_pc),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .wb_vaddr          (wb_vaddr),
        .ws_rf_zip         (ws_rf_zip),
        .ws_pend_mask      (ws_pend_mask),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [189:0] mq[$];
    logic         cur_v;
    logic [189:0] cur_bus;
    logic         cur_stall;
    logic         cur_rst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [189:0] mk(input logic [31:0] pc, input logic [6:0] exc,
            input logic ertn, input logic [31:0] va, input logic we, input logic [4:0] wa,
            input logic [31:0] wd, input logic cre, input logic cwe, input logic [13:0] cnum,
            input logic [31:0] wm, input logic [31:0] wv);
        return {pc, exc, ertn, va, we, wa, wd, cre, cwe, cnum, wm, wv};
    endfunction

    function automatic logic [189:0] rfw(input logic [31:0] pc, input logic [4:0] wa,
            input logic [31:0] wd);
        return mk(pc, 7'd0, 1'b0, 32'd0, 1'b1, wa, wd, 1'b0, 1'b0, 14'd0, 32'd0, 32'd0);
    endfunction

    // exc7 bit order: {int, adef, adem, ale, sys, brk, ine}
    function automatic logic [5:0] x_ecode(input logic [6:0] x);
        if (x[6]) return 6'h0;
        if (x[5]) return 6'h8;
        if (x[4]) return 6'h8;
        if (x[3]) return 6'h9;
        if (x[2]) return 6'hB;
        if (x[1]) return 6'hC;
        return 6'hD;
    endfunction

    function automatic logic [8:0] x_esub(input logic [6:0] x);
        return (!x[6] && !x[5] && x[4]) ? 9'd1 : 9'd0;
    endfunction

    function automatic logic [31:0] x_vaddr(input logic [6:0] x, input logic [31:0] pc,
            input logic [31:0] va);
        if (x[6]) return 32'd0;
        if (x[5]) return pc;
        if (x[4] || x[3]) return va;
        return 32'd0;
    endfunction

    // Apply one cycle of stimulus and compare every output with the reference.
    task automatic drive(input logic v, input logic [189:0] b, input logic stall, input logic rst);
        logic [189:0] h;
        logic [189:0] e;
        logic [6:0]   x;
        logic [4:0]   wa;
        logic [31:0]  wd;
        logic [31:0]  pm;
        logic [37:0]  zip;
        logic         has;
        logic         ret;
        cur_v = v; cur_bus = b; cur_stall = stall; cur_rst = rst;
        bus_if.ms2ws_valid = v;
        bus_if.ms2ws_bus   = b;
        wb_stall = stall;
        reset    = rst;
        #1;
        if (rst) begin
            chk("rst_allowin", bus_if.ws_allowin, 1'b1);
            chk("rst_mask", ws_pend_mask, 32'd0);
            chk("rst_zip", ws_rf_zip, 38'd0);
            chk("rst_ex", wb_ex, 1'b0);
            chk("rst_csr_we", csr_we, 1'b0);
            chk("rst_ertn", ertn_flush, 1'b0);
            chk("rst_pc", wb_pc, 32'd0);
        end else begin
            chk("allowin", bus_if.ws_allowin, mq.size() < DEPTH);
            pm = 32'd0;
            foreach (mq[i]) begin
                e  = mq[i];
                wa = e[116:112];
                if (e[117] && wa != 5'd0) pm[wa] = 1'b1;
            end
            chk("pend_mask", ws_pend_mask, pm);
            if (mq.size() == 0) begin
                chk("idle_pc", wb_pc, 32'd0);
                chk("idle_zip", ws_rf_zip, 38'd0);
                chk("idle_ex", wb_ex, 1'b0);
                chk("idle_csr_re", csr_re, 1'b0);
            end else begin
                h   = mq[0];
                x   = h[157:151];
                has = |x;
                ret = !stall;
                chk("wb_pc", wb_pc, h[189:158]);
                chk("debug_pc", debug_wb_pc, h[189:158]);
                chk("wb_ex", wb_ex, ret & has);
                chk("ertn_flush", ertn_flush, ret & h[150] & !has);
                chk("csr_re", csr_re, h[79]);
                chk("csr_num", csr_num, h[77:64]);
                chk("csr_we", csr_we, ret & h[78] & !has);
                chk("csr_wmask", csr_wmask, h[63:32]);
                chk("csr_wvalue", csr_wvalue, h[31:0]);
                wd  = h[79] ? csr_rvalue : h[111:80];
                zip = {ret & h[117] & !has, h[116:112], wd};
                chk("rf_zip", ws_rf_zip, zip);
                chk("dbg_we", debug_wb_rf_we, {4{zip[37]}});
                chk("dbg_wnum", debug_wb_rf_wnum, h[116:112]);
                chk("dbg_wdata", debug_wb_rf_wdata, wd);
                chk("ecode", wb_ecode, (ret & has) ? x_ecode(x) : 6'd0);
                chk("esub", wb_esubcode, (ret & has) ? x_esub(x) : 9'd0);
                chk("vaddr", wb_vaddr, (ret & has) ? x_vaddr(x, h[189:158], h[149:118]) : 32'd0);
            end
        end
    endtask

    // Advance one clock and update the reference queue the same way.
    task automatic adv();
        logic [189:0] h;
        logic         ret;
        logic         fl;
        int           sz;
        sz = mq.size();
        if (cur_rst) begin
            mq.delete();
        end else begin
            ret = (sz != 0) && !cur_stall;
            fl  = 1'b0;
            if (ret) begin
                h  = mq[0];
                fl = (h[157:151] != 7'd0) || h[150];
            end
            if (fl) begin
                mq.delete();
            end else begin
                if (ret) void'(mq.pop_front());
                if (cur_v && sz < DEPTH) mq.push_back(cur_bus);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [189:0] nb;
        nb = 190'd0;
        csr_rvalue = 32'h1234_5678;
        bus_if.ms2ws_valid = 1'b0;
        bus_if.ms2ws_bus   = nb;
        wb_stall = 1'b0;
        reset    = 1'b1;

        drive(1'b0, nb, 1'b0, 1'b1); adv();
        drive(1'b0, nb, 1'b0, 1'b1); adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("reset_allowin", bus_if.ws_allowin, 1'b1);
        chk("reset_mask", ws_pend_mask, 32'd0);
        adv();

        // 1: fill under stall, then drain; a third entry offered while full is refused
        drive(1'b1, rfw(32'h1C00_0000, 5'd4, 32'h11), 1'b1, 1'b0); adv();
        drive(1'b1, rfw(32'h1C00_0004, 5'd5, 32'h22), 1'b1, 1'b0); adv();
        drive(1'b0, nb, 1'b1, 1'b0);
        chk("t1_full_allowin", bus_if.ws_allowin, 1'b0);
        chk("t1_mask_full", ws_pend_mask, 32'h30);
        chk("t1_stall_no_we", ws_rf_zip[37], 1'b0);
        adv();
        drive(1'b1, rfw(32'h1C00_0008, 5'd9, 32'h99), 1'b0, 1'b0);
        chk("t1_retire_r4", ws_rf_zip, {1'b1, 5'd4, 32'h11});
        chk("t1_allowin_full_retire", bus_if.ws_allowin, 1'b0);
        adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t1_retire_r5", ws_rf_zip, {1'b1, 5'd5, 32'h22});
        chk("t1_mask_after_r4", ws_pend_mask, 32'h20);
        adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t1_mask_empty", ws_pend_mask, 32'h0);
        adv();

        // 2: ALE at the head flushes the entry queued behind it
        drive(1'b1, mk(32'h1C00_0010, 7'b0001000, 1'b0, 32'h1C00_0003, 1'b1, 5'd6, 32'h66,
                        1'b0, 1'b0, 14'd0, 32'd0, 32'd0), 1'b1, 1'b0); adv();
        drive(1'b1, rfw(32'h1C00_0014, 5'd8, 32'h88), 1'b1, 1'b0); adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t2_ex", wb_ex, 1'b1);
        chk("t2_ecode", wb_ecode, 6'h9);
        chk("t2_vaddr", wb_vaddr, 32'h1C00_0003);
        chk("t2_no_rf", debug_wb_rf_we, 4'h0);
        adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t2_empty_pc", wb_pc, 32'd0);
        chk("t2_empty_allowin", bus_if.ws_allowin, 1'b1);
        adv();

        // 3: priority resolution
        drive(1'b1, mk(32'h1C00_0020, 7'b0010001, 1'b0, 32'h0000_0042, 1'b0, 5'd0, 32'd0,
                        1'b0, 1'b0, 14'd0, 32'd0, 32'd0), 1'b0, 1'b0); adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t3_adem_ecode", wb_ecode, 6'h8);
        chk("t3_adem_esub", wb_esubcode, 9'd1);
        chk("t3_adem_vaddr", wb_vaddr, 32'h0000_0042);
        adv();
        drive(1'b1, mk(32'h1C00_0024, 7'b1100000, 1'b0, 32'h0000_0077, 1'b0, 5'd0, 32'd0,
                        1'b0, 1'b0, 14'd0, 32'd0, 32'd0), 1'b0, 1'b0); adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t3_int_ex", wb_ex, 1'b1);
        chk("t3_int_ecode", wb_ecode, 6'h0);
        chk("t3_int_vaddr", wb_vaddr, 32'd0);
        adv();

        // 4: CSR read data forwarded into the rf write, then a CSR write
        drive(1'b1, mk(32'h1C00_0030, 7'd0, 1'b0, 32'd0, 1'b1, 5'd7, 32'h5555_5555,
                        1'b1, 1'b0, 14'h00C, 32'd0, 32'd0), 1'b0, 1'b0); adv();
        csr_rvalue = 32'hDEAD_BEEF;
        drive(1'b1, mk(32'h1C00_0034, 7'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0,
                        1'b0, 1'b1, 14'h005, 32'h0000_00FF, 32'h0000_00A5), 1'b0, 1'b0);
        chk("t4_zip", ws_rf_zip, {1'b1, 5'd7, 32'hDEAD_BEEF});
        chk("t4_dbg_we", debug_wb_rf_we, 4'hF);
        chk("t4_csr_num", csr_num, 14'h00C);
        adv();
        csr_rvalue = 32'h1234_5678;
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t4_csr_we", csr_we, 1'b1);
        chk("t4_csr_wvalue", csr_wvalue, 32'h0000_00A5);
        adv();

        // 5: ertn flush drops the same-cycle arrival; with int set the exception wins
        drive(1'b1, mk(32'h1C00_0040, 7'd0, 1'b1, 32'd0, 1'b0, 5'd0, 32'd0,
                        1'b0, 1'b0, 14'd0, 32'd0, 32'd0), 1'b1, 1'b0); adv();
        drive(1'b1, rfw(32'h1C00_0044, 5'd10, 32'hAA), 1'b0, 1'b0);
        chk("t5_ertn", ertn_flush, 1'b1);
        chk("t5_ertn_no_ex", wb_ex, 1'b0);
        adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t5_dropped_pc", wb_pc, 32'd0);
        chk("t5_dropped_mask", ws_pend_mask, 32'd0);
        adv();
        drive(1'b1, mk(32'h1C00_0048, 7'b1000000, 1'b1, 32'd0, 1'b0, 5'd0, 32'd0,
                        1'b0, 1'b0, 14'd0, 32'd0, 32'd0), 1'b0, 1'b0); adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t5_int_ex", wb_ex, 1'b1);
        chk("t5_int_no_ertn", ertn_flush, 1'b0);
        adv();

        // Streaming with simultaneous enqueue and retire
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rfw(32'h1C00_0100 + 32'(4 * i), 5'(12 + i), 32'(32'h100 + i)),
                  (i == 2), 1'b0);
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, nb, 1'b0, 1'b0); adv();
        end

        // 6: r0 never pending; reset mid-stream clears a full queue
        drive(1'b1, rfw(32'h1C00_0200, 5'd0, 32'hBB), 1'b1, 1'b0); adv();
        drive(1'b1, rfw(32'h1C00_0204, 5'd9, 32'hCC), 1'b1, 1'b0); adv();
        drive(1'b0, nb, 1'b1, 1'b0);
        chk("t6_mask_r0", ws_pend_mask, 32'h0000_0200);
        adv();
        drive(1'b1, rfw(32'h1C00_0208, 5'd3, 32'hDD), 1'b0, 1'b1); adv();
        drive(1'b0, nb, 1'b0, 1'b0);
        chk("t6_post_reset_pc", wb_pc, 32'd0);
        chk("t6_post_reset_mask", ws_pend_mask, 32'd0);
        chk("t6_post_reset_zip", ws_rf_zip, 38'd0);
        chk("t6_post_reset_allowin", bus_if.ws_allowin, 1'b1);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
